// File: rtl/mem_bus_pkg.sv
// Shared types for the core-side single-outstanding memory bus initiator.
// Access sizes, error codes and FSM state encoding.
package mem_bus_pkg;

    localparam int LANES = 8;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } mem_size_e;

    typedef enum logic [1:0] {
        ERR_NONE       = 2'd0,
        ERR_MISALIGNED = 2'd1,
        ERR_TIMEOUT    = 2'd2
    } mem_err_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } init_state_e;

endpackage

// File: rtl/mem_bus_initiator_lane.sv
// Byte-lane steering: load extract with sign/zero extension and
// store merge of a right-justified value into a 64-bit beat.
import mem_bus_pkg::*;

module mem_byte_lane (
    input  logic [63:0]              rdata,
    input  logic [63:0]              wdata,
    input  logic [$clog2(LANES)-1:0] offset,
    input  logic [1:0]               size,
    input  logic                     is_unsigned,
    output logic [63:0]              load_data,
    output logic [63:0]              merged
);

    logic [5:0]  sh;
    logic [63:0] lane;
    logic [63:0] mask;
    logic [63:0] mask_sh;

    assign sh = {offset, 3'b000};

    always_comb begin
        lane      = rdata >> sh;
        load_data = lane;
        mask      = '1;
        unique case (1'b1)
            (size == SZ_B): begin
                load_data = {{56{~is_unsigned & lane[7]}}, lane[7:0]};
                mask      = 64'h0000_0000_0000_00FF;
            end
            (size == SZ_H): begin
                load_data = {{48{~is_unsigned & lane[15]}}, lane[15:0]};
                mask      = 64'h0000_0000_0000_FFFF;
            end
            (size == SZ_W): begin
                load_data = {{32{~is_unsigned & lane[31]}}, lane[31:0]};
                mask      = 64'h0000_0000_FFFF_FFFF;
            end
            (size == SZ_D): begin
                load_data = lane;
                mask      = '1;
            end
            default: ;
        endcase
        mask_sh = mask << sh;
        merged  = (rdata & ~mask_sh) | ((wdata << sh) & mask_sh);
    end

endmodule

// File: rtl/mem_bus_initiator.sv
// Core-side master for the single-outstanding 64-bit memory bus.
// Sub-dword stores are done as read-modify-write since the bus has no strobes.
import mem_bus_pkg::*;

module mem_bus_initiator #(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic [1:0]            rsp_err_code,
    output logic                  mem_request,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    init_state_e           state;
    init_state_e           state_nx;
    logic                  acc;
    logic                  misaligned;
    logic                  expire;
    logic [2:0]            align_mask;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic                  uns_q;
    logic [1:0]            size_q;
    logic [63:0]           wdata_q;
    logic [63:0]           beat_q;
    logic [63:0]           rdata_q;
    mem_err_e              err_q;
    logic [CW-1:0]         tcnt;
    logic [63:0]           load_data;
    logic [63:0]           merged;

    assign req_ready  = (state == ST_IDLE);
    assign acc        = req_valid && req_ready;
    assign align_mask = 3'((4'd1 << req_size) - 4'd1);
    assign misaligned = |(req_addr[2:0] & align_mask);
    // mem_ready in the expiry cycle still completes the beat
    assign expire     = (tcnt == CW'(TIMEOUT_CYCLES - 1)) && !mem_ready;

    mem_byte_lane u_lane (
        .rdata       (mem_rdata),
        .wdata       (wdata_q),
        .offset      (addr_q[2:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .load_data   (load_data),
        .merged      (merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (acc) begin
                    if (misaligned)
                        state_nx = ST_RESP;
                    else if (req_write && req_size == SZ_D)
                        state_nx = ST_WR;
                    else
                        state_nx = ST_RD;
                end
            end
            ST_RD: begin
                if (mem_ready)   state_nx = write_q ? ST_WR : ST_RESP;
                else if (expire) state_nx = ST_RESP;
            end
            ST_WR: begin
                if (mem_ready || expire) state_nx = ST_RESP;
            end
            ST_RESP: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'd0;
            wdata_q <= '0;
            beat_q  <= '0;
            rdata_q <= '0;
            err_q   <= ERR_NONE;
            tcnt    <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (acc) begin
                        addr_q  <= req_addr;
                        write_q <= req_write;
                        uns_q   <= req_unsigned;
                        size_q  <= req_size;
                        wdata_q <= req_wdata;
                        beat_q  <= req_wdata;
                        rdata_q <= '0;
                        err_q   <= misaligned ? ERR_MISALIGNED : ERR_NONE;
                        tcnt    <= '0;
                    end
                end
                ST_RD, ST_WR: begin
                    if (mem_ready) begin
                        tcnt <= '0;
                        if (state == ST_RD && !write_q) rdata_q <= load_data;
                        if (state == ST_RD && write_q)  beat_q  <= merged;
                    end else if (expire) begin
                        err_q <= ERR_TIMEOUT;
                    end else begin
                        tcnt <= tcnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_request  = (state == ST_RD) || (state == ST_WR);
    assign mem_write    = (state == ST_WR);
    assign mem_addr     = mem_request ? {addr_q[ADDR_WIDTH-1:3], 3'b000} : '0;
    assign mem_wdata    = mem_write ? beat_q : '0;
    assign rsp_valid    = (state == ST_RESP);
    assign rsp_rdata    = rsp_valid ? rdata_q : '0;
    assign rsp_error    = rsp_valid && (err_q != ERR_NONE);
    assign rsp_err_code = rsp_valid ? err_q : ERR_NONE;

endmodule
